// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing controller: line synchronizer, start-edge
// detection, mid-bit baud_tick generation, show-ahead receive FIFO on a
// valid/ready stream, and saturating overrun / framing-error counters.
module uart_rx_ctrl #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          rxd_in,
  output logic                          rxd,
  output logic                          baud_tick,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    overrun_cnt,
  output logic [7:0]                    frame_err_cnt,
  input  logic                          stat_clr,
  output logic                          busy
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(2);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HALF = 2'd1;
  localparam logic [1:0] S_BITS = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic          rxd_meta;
  logic          rxd_prev;
  logic          fall;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    tick_idx;
  logic          half_done;
  logic          bit_done;
  logic          wait_done;
  logic          frame_err_evt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          overrun_evt;

  // Two-flop synchronizer plus previous-value register for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd      <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd_in;
      rxd      <= rxd_meta;
      rxd_prev <= rxd;
    end
  end

  assign fall          = rxd_prev & ~rxd;
  assign half_done     = (state == S_HALF) && (cnt == HALF_LAST);
  assign bit_done      = (state == S_BITS) && (cnt == BIT_LAST);
  assign wait_done     = (state == S_WAIT) && (cnt == WAIT_LAST);
  assign frame_err_evt = wait_done && !rx_valid;
  assign baud_tick     = (half_done && !rxd) || bit_done;
  assign busy          = (state != S_IDLE);

  // Frame sequencer: half-bit alignment, ten bit ticks, then byte wait window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      tick_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && fall) begin
            state <= S_HALF;
            cnt   <= '0;
          end
        end
        S_HALF: begin
          if (half_done) begin
            cnt <= '0;
            if (!rxd) begin
              tick_idx <= 4'd1;
              state    <= S_BITS;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_BITS: begin
          if (bit_done) begin
            cnt      <= '0;
            tick_idx <= tick_idx + 4'd1;
            if (tick_idx == 4'd9) state <= S_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (rx_valid || wait_done) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // is accepted when a pop coincides with it.
  assign full        = (fifo_level == LVL_FULL);
  assign pop         = m_valid && m_ready;
  assign push_ok     = rx_valid && (!full || pop);
  assign overrun_evt = rx_valid && full && !pop;
  assign m_valid     = (fifo_level != '0);
  assign m_data      = m_valid ? mem[rd_ptr] : '0;

  // FIFO storage write; contents need no reset since occupancy gates m_data
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      fifo_level <= fifo_level + LW'(1);
      else if (pop && !push_ok) fifo_level <= fifo_level - LW'(1);
    end
  end

  // Saturating overrun counter; clear has priority over increment
  always_ff @(posedge clk) begin
    if (!rst_n)                                  overrun_cnt <= '0;
    else if (stat_clr)                           overrun_cnt <= '0;
    else if (overrun_evt && overrun_cnt != '1)   overrun_cnt <= overrun_cnt + 8'd1;
  end

  // Saturating framing-error counter; clear has priority over increment
  always_ff @(posedge clk) begin
    if (!rst_n)                                    frame_err_cnt <= '0;
    else if (stat_clr)                             frame_err_cnt <= '0;
    else if (frame_err_evt && frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + 8'd1;
  end

endmodule
